// File: rtl/banner_reader_if.sv
// Pixel-position, ROM and output signals of the banner reader, bundled for the
// timing-generator side (master) and the reader itself (slave).
interface banner_reader_if;
  logic        frame_start;
  logic        show;
  logic        pix_ce;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [3:0]  rom_addr;
  logic [71:0] rom_data;
  logic        pixel_on;
  logic        busy;

  modport master (
    output frame_start, show, pix_ce, DrawX, DrawY, rom_data,
    input  rom_addr, pixel_on, busy
  );

  modport slave (
    input  frame_start, show, pix_ce, DrawX, DrawY, rom_data,
    output rom_addr, pixel_on, busy
  );
endinterface

// File: rtl/banner_reader.sv
// Serialises a 16x72 banner ROM into a per-pixel on/off stream at a fixed
// screen origin, with power-of-two replication in X and Y.
module banner_reader #(
  parameter int X0         = 284,
  parameter int Y0         = 232,
  parameter int SCALE_LOG2 = 0
) (
  input logic             Clk,
  input logic             Reset_n,
  banner_reader_if.slave  bus
);

  localparam int H = 16 << SCALE_LOG2;
  localparam logic [10:0] Y_LO    = 11'(Y0);
  localparam logic [10:0] Y_HI    = 11'(Y0 + H);
  localparam logic [9:0]  Y_LAST  = 10'(Y0 + H - 1);
  localparam logic [9:0]  Y_BASE  = 10'(Y0);
  localparam logic [9:0]  X_PRE   = 10'(X0 - 1);
  localparam logic [1:0]  REP_MAX = 2'((1 << SCALE_LOG2) - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    ADDR  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  rom_addr_r, rom_addr_s;
  logic [71:0] shreg_r, shreg_s;
  logic [1:0]  rep_r, rep_s;
  logic [6:0]  col_r, col_s;
  logic        pix_r, pix_s;
  logic        busy_r;
  logic        in_line_s;
  logic [9:0]  dy_s;
  logic [3:0]  row_s;

  assign dy_s      = bus.DrawY - Y_BASE;
  assign row_s     = 4'(dy_s >> SCALE_LOG2);
  assign in_line_s = ({1'b0, bus.DrawY} >= Y_LO) && ({1'b0, bus.DrawY} < Y_HI);

  // Next-state and datapath: frame_start overrides any coincident pixel strobe.
  always_comb begin
    state_s    = state_r;
    rom_addr_s = rom_addr_r;
    shreg_s    = shreg_r;
    rep_s      = rep_r;
    col_s      = col_r;
    pix_s      = pix_r;
    if (bus.frame_start) begin
      pix_s   = 1'b0;
      shreg_s = 72'd0;
      state_s = bus.show ? ARMED : IDLE;
    end else if (bus.pix_ce) begin
      case (state_r)
        IDLE: begin
          pix_s = 1'b0;
        end
        ARMED: begin
          pix_s = 1'b0;
          if ((bus.DrawX == 10'd0) && in_line_s) begin
            rom_addr_s = row_s;
            state_s    = ADDR;
          end else begin
            state_s = ARMED;
          end
        end
        ADDR: begin
          pix_s = 1'b0;
          if (bus.DrawX == X_PRE) begin
            shreg_s = bus.rom_data;
            rep_s   = 2'd0;
            col_s   = 7'd0;
            state_s = SHIFT;
          end else begin
            state_s = ADDR;
          end
        end
        SHIFT: begin
          if (col_r == 7'd72) begin
            pix_s   = 1'b0;
            state_s = (bus.DrawY == Y_LAST) ? DONE : ARMED;
          end else begin
            pix_s = shreg_r[71];
            // Each ROM column is repeated 2^SCALE_LOG2 strobes before advancing.
            if (rep_r == REP_MAX) begin
              rep_s   = 2'd0;
              shreg_s = {shreg_r[70:0], 1'b0};
              col_s   = col_r + 7'd1;
            end else begin
              rep_s = rep_r + 2'd1;
            end
          end
        end
        DONE: begin
          pix_s = 1'b0;
        end
        default: begin
          pix_s   = 1'b0;
          state_s = IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and datapath registers; busy is registered from the next state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r    <= IDLE;
      rom_addr_r <= 4'd0;
      shreg_r    <= 72'd0;
      rep_r      <= 2'd0;
      col_r      <= 7'd0;
      pix_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      rom_addr_r <= rom_addr_s;
      shreg_r    <= shreg_s;
      rep_r      <= rep_s;
      col_r      <= col_s;
      pix_r      <= pix_s;
      busy_r     <= (state_s == ARMED) || (state_s == ADDR) || (state_s == SHIFT);
    end
  end

  assign bus.rom_addr = rom_addr_r;
  assign bus.pixel_on = pix_r;
  assign bus.busy     = busy_r;

endmodule

// File: doc/banner_reader.md
Name: banner_reader

Overview:
- Reads the 16-row x 72-column banner bitmap ROM (e.g. the GAME OVER / READY text ROMs) one row at a time and serialises it into a per-pixel on/off stream.
- Sits between the VGA pixel-position generator and the colour mapper; the colour mapper ORs pixel_on into its text layer.
- Supports a fixed screen origin and power-of-two pixel replication (scaling).

Parameters:
- X0, 284, left screen column of the banner; must be >= 2.
- Y0, 232, top screen line of the banner.
- SCALE_LOG2, 0, replication factor 2^SCALE_LOG2 in both X and Y; legal values 0..2.

Ports:
- Clk  input  1  system clock.
- Reset_n  input  1  asynchronous active-low reset.
- frame_start  input  1  one-cycle pulse at the start of each frame (before line 0).
- show  input  1  banner enable; sampled only on frame_start.
- pix_ce  input  1  one-cycle strobe; DrawX/DrawY are valid and new on this cycle.
- DrawX  input  10  current pixel column.
- DrawY  input  10  current pixel line.
- rom_addr  output  4  row address to the banner ROM.
- rom_data  input  72  ROM row; combinational, valid in the same cycle as rom_addr. Bit 71 is the leftmost column.
- pixel_on  output  1  banner pixel for the DrawX/DrawY of the most recent pix_ce.
- busy  output  1  high while a banner is armed or being drawn this frame.

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE; rom_addr=0; shreg=0; rep_cnt=0; col_cnt=0.
  - pixel_on=0; busy=0.
- Definitions:
  - H = 16<<SCALE_LOG2; W = 72<<SCALE_LOG2.
  - Line in window: Y0 <= DrawY < Y0+H.
  - Column in window: X0 <= DrawX < X0+W.
- All state updates except frame_start handling happen only on cycles with pix_ce=1.
- States:
  - IDLE: on frame_start with show=1 -> ARMED (busy=1); with show=0, stay in IDLE.
  - ARMED: pix_ce with DrawX==0 and line in window: rom_addr <= (DrawY-Y0)>>SCALE_LOG2, -> ADDR.
  - ADDR: pix_ce with DrawX==X0-1: shreg <= rom_data, rep_cnt=0, col_cnt=0, -> SHIFT.
  - SHIFT: each pix_ce, pixel_on <= shreg[71]; rep_cnt increments.
    - When rep_cnt wraps (2^SCALE_LOG2 strobes): shreg <= shreg<<1, col_cnt++.
    - After col_cnt reaches 72, pixel_on <= 0 and:
      - if DrawY == Y0+H-1 -> DONE;
      - else -> ARMED.
  - DONE: busy=0, pixel_on=0; leave only on frame_start (same rules as IDLE).
- pixel_on:
  - Registered; updates on the clock edge that samples pix_ce.
  - Holds its value between strobes.
  - Forced to 0 in every state except SHIFT.
  - Latency: 1 clock from pix_ce.
- frame_start in any state:
  - Abort the current frame; pixel_on <= 0; shreg <= 0.
  - Next state = ARMED if show=1, else IDLE.
  - frame_start takes priority over a coincident pix_ce.
- show changes mid-frame are ignored until the next frame_start.
- Row index range: always 0..15 by construction; no wrap logic is needed.
- A line whose DrawX==0 strobe is missed (no pix_ce at column 0) is skipped: pixel_on stays 0 for that line and the state remains ARMED.

Test Plan:
1. Reset_n=0 mid-SHIFT -> pixel_on=0, busy=0, rom_addr=0 immediately (asynchronous); after release, state IDLE until frame_start.
2. SCALE_LOG2=0, show=1, frame_start, then sweep DrawY=235 -> rom_addr=3. DrawX 284/285/286/287 -> pixel_on 0/1/1/0. DrawX 356 -> 0.
3. Same frame, DrawY=232 (row 0, all zero) -> pixel_on=0 across X 284..355. DrawY=244, DrawX=286 -> pixel_on=1. After DrawY=247 line ends -> DONE, busy=0.
4. show=0 at frame_start -> pixel_on=0 for the whole frame, busy=0. Raising show mid-frame has no effect until the next frame_start.
5. SCALE_LOG2=1: DrawY=238 and 239 -> rom_addr=3 on both lines. DrawX 284,285 -> 0; 286,287 -> 1; 288,289 -> 1; 290,291 -> 0. Window ends at DrawX=427.
6. frame_start asserted while in SHIFT at DrawX=300, coincident with pix_ce -> next cycle pixel_on=0, state ARMED, no further ROM bits output on that line.
